// File: rtl/key_sched_rd.sv
// key_sched_rd: walks the expanded AES key schedule held in a 64-bit wide
// RAM and presents one 128-bit round key at a time to a consumer.
// Each key takes two RAM reads: the high half, then the low half.
// Keys are delivered in order 0..Nr for encrypt and Nr..0 for decrypt.
module key_sched_rd (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   key_mode,
  input  logic         key_ready,
  input  logic         decrypt,
  input  logic         rk_req,
  input  logic         rk_next,
  output logic         rd,
  output logic [4:0]   rd_addr,
  input  logic [63:0]  rd_data,
  output logic [127:0] rk,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_HI = 3'd1,
    RD_LO = 3'd2,
    CAPT  = 3'd3,
    VALID = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     r_q, r_d;        // current round index
  logic [3:0]     nr_q, nr_d;      // round count latched at start of sequence
  logic           dec_q, dec_d;    // direction latched at start of sequence
  logic [127:0]   rk_q, rk_d;
  logic           last;

  // Round count for a key size; mode 3 behaves as a 256-bit key.
  function automatic logic [3:0] mode_nr(input logic [1:0] m);
    case (m)
      2'd0:    mode_nr = 4'd10;
      2'd1:    mode_nr = 4'd12;
      default: mode_nr = 4'd14;
    endcase
  endfunction

  // The key on rk is the final one once r reaches the far end of the schedule.
  assign last = dec_q ? (r_q == 4'd0) : (r_q == nr_q);

  // Next-state and datapath update; an absent schedule aborts any sequence.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    nr_d    = nr_q;
    dec_d   = dec_q;
    rk_d    = rk_q;
    if (state_q != IDLE && !key_ready) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rk_req && key_ready) begin
            nr_d    = mode_nr(key_mode);
            dec_d   = decrypt;
            r_d     = decrypt ? mode_nr(key_mode) : 4'd0;
            state_d = RD_HI;
          end
        end
        RD_HI: state_d = RD_LO;
        RD_LO: begin
          // Data for the high-half read issued in RD_HI arrives now.
          rk_d[127:64] = rd_data;
          state_d      = CAPT;
        end
        CAPT: begin
          rk_d[63:0] = rd_data;
          state_d    = VALID;
        end
        VALID: begin
          if (rk_next) begin
            if (last) begin
              state_d = IDLE;
            end else begin
              r_d     = dec_q ? r_q - 4'd1 : r_q + 4'd1;
              state_d = RD_HI;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register; reset clears everything so all outputs read zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= 4'd0;
      nr_q    <= 4'd0;
      dec_q   <= 1'b0;
      rk_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      nr_q    <= nr_d;
      dec_q   <= dec_d;
      rk_q    <= rk_d;
    end
  end

  // Outputs are decoded from registered state only, so no input reaches
  // rd/rd_addr combinationally.
  always_comb begin
    rd       = (state_q == RD_HI) || (state_q == RD_LO);
    rd_addr  = 5'd0;
    if (rd) rd_addr = {r_q, state_q == RD_LO};
    rk       = rk_q;
    rk_valid = (state_q == VALID);
    rk_round = r_q;
    rk_last  = (state_q == VALID) && last;
    busy     = (state_q != IDLE);
  end

endmodule

// File: tb/tb_key_sched_rd.sv
// Bench for key_sched_rd: a RAM model answers reads one cycle later, and a
// reference model derives the expected round sequence and key contents
// directly from the key size, direction and RAM image.
module tb_key_sched_rd;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   key_mode;
  logic         key_ready;
  logic         decrypt;
  logic         rk_req;
  logic         rk_next;
  logic         rd;
  logic [4:0]   rd_addr;
  logic [63:0]  rd_data;
  logic [127:0] rk;
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         busy;

  logic [63:0]  mem [0:31];
  int           vectors = 0;
  int           miscompares = 0;

  localparam logic [127:0] FIPS_RK0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  key_sched_rd dut (
    .clk(clk), .reset(reset), .key_mode(key_mode), .key_ready(key_ready),
    .decrypt(decrypt), .rk_req(rk_req), .rk_next(rk_next), .rd(rd),
    .rd_addr(rd_addr), .rd_data(rd_data), .rk(rk), .rk_valid(rk_valid),
    .rk_round(rk_round), .rk_last(rk_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Expanded-key RAM: data for a read appears the cycle after rd.
  always @(posedge clk) if (rd) rd_data <= mem[rd_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Run one full sequence, checking every key against the model.
  task automatic run_seq(input logic [1:0] mode, input logic dec,
                         output int nkeys, output logic [127:0] first_rk,
                         output logic [127:0] final_rk, output logic [4:0] max_addr);
    int nr;
    int r;
    int n;
    logic [4:0]   addrs[$];
    logic [127:0] hold_rk;
    logic [3:0]   hold_rnd;
    nr = (mode == 2'd0) ? 10 : (mode == 2'd1) ? 12 : 14;
    nkeys = 0; max_addr = 0; first_rk = '0; final_rk = '0;
    key_mode = mode; decrypt = dec; rk_req = 1'b1;
    tick;
    rk_req = 1'b0;
    // later mode/direction changes must not matter
    key_mode = 2'($urandom); decrypt = 1'($urandom);
    for (int k = 0; k <= nr; k++) begin
      r = dec ? nr - k : k;
      addrs.delete();
      n = 1;
      while (!rk_valid && n < 20) begin
        if (rd) begin
          addrs.push_back(rd_addr);
          if (rd_addr > max_addr) max_addr = rd_addr;
        end
        rk_next = 1'($urandom); rk_req = 1'($urandom);
        tick;
        n++;
      end
      rk_next = 1'b0; rk_req = 1'b0;
      vectors++;
      if (n != 4) begin
        miscompares++;
        $display("FAIL latency key %0d: valid after %0d cycles, want 4", k, n);
      end
      vectors++;
      if (addrs.size() != 2 || addrs[0] !== 5'(2*r) || addrs[1] !== 5'(2*r+1)) begin
        miscompares++;
        $display("FAIL rd_addr key %0d: %0d reads, want addrs %0d,%0d", k, addrs.size(), 2*r, 2*r+1);
      end
      vectors++;
      if (rk !== {mem[2*r], mem[2*r+1]}) begin
        miscompares++;
        $display("FAIL rk round %0d: got %h want %h", r, rk, {mem[2*r], mem[2*r+1]});
      end
      vectors++;
      if (rk_round !== 4'(r)) begin
        miscompares++;
        $display("FAIL rk_round: got %0d want %0d", rk_round, r);
      end
      vectors++;
      if (rk_last !== (k == nr)) begin
        miscompares++;
        $display("FAIL rk_last round %0d: got %b want %b", r, rk_last, k == nr);
      end
      if (k == 0) first_rk = rk;
      final_rk = rk;
      nkeys++;
      hold_rk = rk; hold_rnd = rk_round;
      repeat ($urandom_range(0, 2)) begin
        rk_req = 1'($urandom);
        tick;
        vectors++;
        if (rk_valid !== 1'b1 || rk !== hold_rk || rk_round !== hold_rnd) begin
          miscompares++;
          $display("FAIL hold round %0d: valid %b rk %h round %0d", r, rk_valid, rk, rk_round);
        end
      end
      rk_next = 1'b1; rk_req = 1'($urandom);
      tick;
      rk_next = 1'b0; rk_req = 1'b0;
    end
    vectors++;
    if (rk_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL end of sequence: valid %b busy %b, want 0 0", rk_valid, busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; key_ready = 1'($urandom); rk_req = 1'b1; rk_next = 1'b1;
    key_mode = 2'($urandom); decrypt = 1'($urandom);
    tick; tick;
    vectors++;
    if ({rd, rd_addr, rk, rk_valid, rk_round, rk_last, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset: rd %b addr %0d rk %h valid %b round %0d last %b busy %b",
               rd, rd_addr, rk, rk_valid, rk_round, rk_last, busy);
    end
    reset = 1'b0; rk_req = 1'b0; rk_next = 1'b0; key_ready = 1'b1;
    tick;
  endtask

  task automatic test_enc128;
    int nk; logic [127:0] f, l; logic [4:0] ma;
    run_seq(2'd0, 1'b0, nk, f, l, ma);
    vectors++;
    if (nk != 11 || f !== FIPS_RK0 || l !== FIPS_RK10 || ma !== 5'd21) begin
      miscompares++;
      $display("FAIL enc128: keys %0d first %h last %h maxaddr %0d, want 11 %h %h 21",
               nk, f, l, ma, FIPS_RK0, FIPS_RK10);
    end
  endtask

  task automatic test_dec256;
    int nk; logic [127:0] f, l; logic [4:0] ma;
    run_seq(2'd2, 1'b1, nk, f, l, ma);
    vectors++;
    if (nk != 15 || ma !== 5'd29 || f !== {mem[28], mem[29]} || l !== FIPS_RK0) begin
      miscompares++;
      $display("FAIL dec256: keys %0d maxaddr %0d first %h last %h", nk, ma, f, l);
    end
  endtask

  task automatic test_enc192;
    int nk; logic [127:0] f, l; logic [4:0] ma;
    run_seq(2'd1, 1'b0, nk, f, l, ma);
    vectors++;
    if (nk != 13 || ma !== 5'd25 || l !== {mem[24], mem[25]}) begin
      miscompares++;
      $display("FAIL enc192: keys %0d maxaddr %0d last %h, want 13 25", nk, ma, l);
    end
  endtask

  task automatic test_abort;
    int nk; logic [127:0] f, l; logic [4:0] ma;
    logic seen;
    key_mode = 2'd0; decrypt = 1'b0; rk_req = 1'b1;
    tick;                 // now RD_HI
    rk_req = 1'b0;
    tick;                 // now RD_LO
    key_ready = 1'b0;
    tick;
    vectors++;
    if (busy !== 1'b0 || rd !== 1'b0 || rk_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: busy %b rd %b valid %b, want 0 0 0", busy, rd, rk_valid);
    end
    seen = 1'b0;
    repeat (5) begin tick; if (rk_valid) seen = 1'b1; end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL abort valid: rk_valid rose after abort, want never");
    end
    key_ready = 1'b1;
    run_seq(2'd0, 1'b0, nk, f, l, ma);
    vectors++;
    if (f !== FIPS_RK0) begin
      miscompares++;
      $display("FAIL restart: first key %h want %h", f, FIPS_RK0);
    end
  endtask

  task automatic test_reset_in_valid;
    key_mode = 2'd0; decrypt = 1'b0; rk_req = 1'b1;
    tick;
    rk_req = 1'b0;
    repeat (3) tick;
    vectors++;
    if (rk_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre-reset valid: got %b want 1", rk_valid);
    end
    reset = 1'b1; rk_next = 1'b1; rk_req = 1'b1;
    tick;
    reset = 1'b0; rk_next = 1'b0; rk_req = 1'b0;
    vectors++;
    if ({rd, rd_addr, rk, rk_valid, rk_round, rk_last, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset in valid: rd %b addr %0d rk %h valid %b round %0d last %b busy %b",
               rd, rd_addr, rk, rk_valid, rk_round, rk_last, busy);
    end
    key_ready = 1'b0; rk_req = 1'b1;
    tick;
    rk_req = 1'b0;
    tick;
    vectors++;
    if (busy !== 1'b0 || rd !== 1'b0) begin
      miscompares++;
      $display("FAIL req without key_ready: busy %b rd %b, want 0 0", busy, rd);
    end
    key_ready = 1'b1;
    tick;
  endtask

  task automatic test_random;
    int nk; logic [127:0] f, l; logic [4:0] ma;
    logic [1:0] m; logic d;
    int nr;
    repeat (6) begin
      m = 2'($urandom); d = 1'($urandom);
      nr = (m == 2'd0) ? 10 : (m == 2'd1) ? 12 : 14;
      run_seq(m, d, nk, f, l, ma);
      vectors++;
      if (nk != nr + 1 || ma !== 5'(2*nr+1)) begin
        miscompares++;
        $display("FAIL random mode %0d dec %b: keys %0d maxaddr %0d, want %0d %0d",
                 m, d, nk, ma, nr + 1, 2*nr + 1);
      end
      repeat ($urandom_range(0, 3)) tick;
    end
  endtask

  initial begin
    // first and last round keys of the FIPS-197 128-bit example, rest random
    for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
    mem[0] = FIPS_RK0[127:64];  mem[1]  = FIPS_RK0[63:0];
    mem[20] = FIPS_RK10[127:64]; mem[21] = FIPS_RK10[63:0];
    reset = 1'b1; key_mode = 2'd0; key_ready = 1'b0; decrypt = 1'b0;
    rk_req = 1'b0; rk_next = 1'b0;
    test_reset;
    test_enc128;
    test_dec256;
    test_enc192;
    test_abort;
    test_reset_in_valid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
